// File: rtl/emd_recon.sv
// emd_recon -- EMD reconstruction: Xrec = IMF1 (delayed DLY strobes) + IMF2 + R2,
// summed at W+2 bits and saturated to W bits.
//
// Ports:
//   CLK    in  1  system clock, rising edge
//   RST    in  1  synchronous active-high reset
//   Vin    in  1  sample strobe, qualifies IMF1/IMF2/R2
//   IMF1   in  W  first IMF (leads IMF2/R2 by DLY strobes)
//   IMF2   in  W  second IMF
//   R2     in  W  second-stage residue
//   Xrec   out W  reconstructed, saturated sample (holds when Vout=0)
//   Vout   out 1  Xrec valid, one cycle after an accepted strobe in RUN
//   Sat    out 1  Xrec was clipped (holds when Vout=0)
//   Filled out 1  delay line holds DLY samples
module emd_recon #(
  parameter int W   = 16,
  parameter int DLY = 120
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Vin,
  input  logic [W-1:0] IMF1,
  input  logic [W-1:0] IMF2,
  input  logic [W-1:0] R2,
  output logic [W-1:0] Xrec,
  output logic         Vout,
  output logic         Sat,
  output logic         Filled
);

  localparam int AW = (DLY > 1) ? $clog2(DLY) : 1;
  localparam logic [AW-1:0] LAST = AW'(DLY - 1);
  localparam logic [7:0]    CMAX = 8'(DLY);
  localparam logic signed [W+1:0] MAXV = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MINV = {3'b111, {(W-1){1'b0}}};

  typedef enum logic {FILL, RUN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_cnt;
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [W-1:0]      r_mem [DLY];
  logic [W-1:0]      w_d1;
  logic signed [W+1:0] w_sum;
  logic              w_run_strobe;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= FILL;
    else     r_state <= w_next;
  end

  // Next-state logic: leave FILL on the DLY-th accepted strobe
  always_comb begin
    w_next = r_state;
    if (r_state == FILL && Vin && r_cnt == CMAX - 8'd1)
      w_next = RUN;
  end

  // Output decode
  always_comb begin
    Filled       = (r_state == RUN);
    w_run_strobe = Vin && (r_state == RUN);
  end

  // Fill counter stops at DLY once RUN is reached
  always_ff @(posedge CLK) begin
    if (RST)                           r_cnt <= '0;
    else if (Vin && r_state == FILL)   r_cnt <= r_cnt + 8'd1;
  end

  // With depth DLY the slot read this strobe (written DLY strobes ago) is the
  // same slot written now, so rp and wp advance in lockstep.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (Vin) begin
      r_wp <= (r_wp == LAST) ? '0 : r_wp + 1'b1;
      r_rp <= (r_rp == LAST) ? '0 : r_rp + 1'b1;
    end
  end

  // Delay line storage, not reset; stale data is masked by FILL
  always_ff @(posedge CLK) begin
    if (!RST && Vin) r_mem[r_wp] <= IMF1;
  end

  // Asynchronous read returns the old contents before this edge's write
  assign w_d1  = r_mem[r_rp];
  assign w_sum = $signed({{2{w_d1[W-1]}}, w_d1})
               + $signed({{2{IMF2[W-1]}}, IMF2})
               + $signed({{2{R2[W-1]}}, R2});

  // Registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      Xrec <= '0;
      Sat  <= 1'b0;
      Vout <= 1'b0;
    end else begin
      Vout <= w_run_strobe;
      if (w_run_strobe) begin
        if (w_sum > MAXV) begin
          Xrec <= MAXV[W-1:0];
          Sat  <= 1'b1;
        end else if (w_sum < MINV) begin
          Xrec <= MINV[W-1:0];
          Sat  <= 1'b1;
        end else begin
          Xrec <= w_sum[W-1:0];
          Sat  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_emd_recon.sv
// tb_emd_recon -- scoreboard bench for emd_recon (W=16, DLY=120).
module tb_emd_recon;

  localparam int W    = 16;
  localparam int DLY  = 120;
  localparam int MAXI = 32767;
  localparam int MINI = -32768;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         Vin = 1'b0;
  logic [W-1:0] IMF1 = '0;
  logic [W-1:0] IMF2 = '0;
  logic [W-1:0] R2   = '0;
  logic [W-1:0] Xrec;
  logic         Vout;
  logic         Sat;
  logic         Filled;

  emd_recon #(.W(W), .DLY(DLY)) dut (
    .CLK(CLK), .RST(RST), .Vin(Vin), .IMF1(IMF1), .IMF2(IMF2), .R2(R2),
    .Xrec(Xrec), .Vout(Vout), .Sat(Sat), .Filled(Filled)
  );

  always #5 CLK = ~CLK;

  typedef struct { int x; bit s; } exp_t;
  exp_t q[$];
  int   hist[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int clip(input int s);
    if (s > MAXI) return MAXI;
    if (s < MINI) return MINI;
    return s;
  endfunction

  // Monitor: every Vout must match the oldest expected entry
  always @(negedge CLK) begin
    if (Vout) begin
      if (q.size() == 0) begin
        chk("unexpected_vout", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("xrec", int'($signed(Xrec)), e.x);
        chk("sat", int'(Sat), int'(e.s));
      end
    end
  end

  // One accepted strobe. hand=1 uses the supplied expectation, else the
  // delayed-IMF1 model. gap=1 follows the strobe with one idle cycle.
  task automatic strobe(input int a, input int b, input int c,
                        input bit hand, input int hx, input bit hs, input bit gap);
    exp_t e;
    @(negedge CLK);
    chk("filled", int'(Filled), int'(hist.size() >= DLY));
    Vin  = 1'b1;
    IMF1 = W'(a);
    IMF2 = W'(b);
    R2   = W'(c);
    if (hist.size() >= DLY) begin
      if (hand) begin
        e.x = hx; e.s = hs;
      end else begin
        int s;
        s   = hist[hist.size() - DLY] + b + c;
        e.x = clip(s);
        e.s = (s > MAXI) || (s < MINI);
      end
      q.push_back(e);
    end
    hist.push_back(a);
    if (gap) begin
      @(negedge CLK);
      Vin = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles, input bit vin_hi);
    @(negedge CLK);
    RST  = 1'b1;
    Vin  = vin_hi;
    IMF1 = W'(7777);
    @(negedge CLK);
    chk("rst_xrec", int'(Xrec), 0);
    chk("rst_vout", int'(Vout), 0);
    chk("rst_sat", int'(Sat), 0);
    chk("rst_filled", int'(Filled), 0);
    Vin = 1'b0;
    repeat (cycles - 1) @(negedge CLK);
    RST = 1'b0;
    hist.delete();
  endtask

  initial begin
    // Fill + wrap: 2000-strobe continuous ramp
    do_reset(2, 1'b0);
    for (int k = 0; k < 2000; k++) strobe(k, 0, 0, 1'b0, 0, 1'b0, 1'b0);

    // Mid-run reset: stale offset ramp, reset with Vin=1, then fresh ramp
    do_reset(2, 1'b0);
    for (int k = 0; k < 500; k++) strobe(k + 1000, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    do_reset(1, 1'b1);
    for (int k = 0; k < 200; k++) strobe(k, 0, 0, 1'b0, 0, 1'b0, 1'b0);

    // Gaps: one idle cycle after every strobe
    do_reset(2, 1'b0);
    for (int k = 0; k < 300; k++) strobe(k, 0, 0, 1'b0, 0, 1'b0, 1'b1);

    // Alignment: IMF1=100 only at strobe 5 (1-based), IMF2=20, R2=3
    do_reset(2, 1'b0);
    for (int n = 1; n <= 130; n++)
      strobe((n == 5) ? 100 : 0, 20, 3, 1'b1, (n == 125) ? 123 : 23, 1'b0, 1'b0);

    // Saturation and range boundaries
    do_reset(2, 1'b0);
    for (int k = 0; k < DLY; k++)
      strobe((k % 2 == 0) ? 30000 : -30000, 0, 0, 1'b1, 0, 1'b0, 1'b0);
    strobe(0,  5000,  0, 1'b1, MAXI, 1'b1, 1'b0);
    strobe(0, -5000, -1, 1'b1, MINI, 1'b1, 1'b0);
    strobe(0,  2767,  0, 1'b1, MAXI, 1'b0, 1'b0);
    strobe(0, -2768,  0, 1'b1, MINI, 1'b0, 1'b0);
    @(negedge CLK);
    Vin = 1'b0;
    repeat (3) @(negedge CLK);
    chk("hold_xrec", int'($signed(Xrec)), MINI);
    chk("hold_sat", int'(Sat), 0);
    chk("hold_vout", int'(Vout), 0);

    repeat (3) @(negedge CLK);
    chk("missing_outputs", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
